adxl_spi_responder: RTL and testbench

- SPI slave model of the ADXL345 accelerometer: the responder end of the 4-wire SPI link driven by the accelerometer config/read master.
- Holds a 64-byte register file, accepts master writes, and returns register contents on reads, including multi-byte burst reads.
- Captures host-supplied X/Y/Z samples, generates DATA_READY and the INT1/INT2 pins.
- Used as the sensor stand-in for bench/loopback testing of the master, and on a second FPGA pin set.

---
 rtl/adxl_spi_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_adxl_spi_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl_spi_responder.sv
// ADXL345-style SPI mode-3 slave: 64-byte register file, burst reads, sample capture and INT pins.
// All SPI inputs are synchronised to iSPI_CLK; SDO updates a few system cycles after each SCLK fall.
module adxl_spi_responder #(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        iSPI_CLK,
  input  logic        iRSTN,
  input  logic        iSCLK,
  input  logic        iCSN,
  input  logic        iSDI,
  output logic        oSDO,
  output logic        oSDO_OE,
  input  logic [15:0] iX_DATA,
  input  logic [15:0] iY_DATA,
  input  logic [15:0] iZ_DATA,
  input  logic        iSAMPLE_VALID,
  output logic        oINT1,
  output logic        oINT2,
  output logic        oMEASURE,
  output logic        oWR_STB,
  output logic [5:0]  oWR_ADDR,
  output logic [7:0]  oWR_DATA
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [5:0] A_DEVID       = 6'h00;
  localparam logic [5:0] A_BW_RATE     = 6'h2C;
  localparam logic [5:0] A_POWER_CTL   = 6'h2D;
  localparam logic [5:0] A_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] A_INT_MAP     = 6'h2F;
  localparam logic [5:0] A_INT_SOURCE  = 6'h30;
  localparam logic [5:0] A_DATA_FORMAT = 6'h31;
  localparam logic [5:0] A_DATAX0      = 6'h32;
  localparam logic [5:0] A_DATAX1      = 6'h33;
  localparam logic [5:0] A_DATAY0      = 6'h34;
  localparam logic [5:0] A_DATAY1      = 6'h35;
  localparam logic [5:0] A_DATAZ0      = 6'h36;
  localparam logic [5:0] A_DATAZ1      = 6'h37;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_s;
  logic                   csn_s;
  logic                   sdi_s;
  logic                   sclk_q;
  logic                   csn_q;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   csn_rise;
  logic                   csn_fall;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx;
  logic [7:0]  rx_next;
  logic [7:0]  tx;
  logic        rw;
  logic        mb;
  logic [5:0]  addr;
  logic [5:0]  addr_next;
  logic [7:0]  regs [64];

  logic        cap_vld;
  logic        pend;
  logic [15:0] pend_x;
  logic [15:0] pend_y;
  logic [15:0] pend_z;
  logic        load_vld;
  logic [15:0] load_x;
  logic [15:0] load_y;
  logic [15:0] load_z;
  logic [7:0]  act;

  function automatic logic is_ro(input logic [5:0] a);
    return (a == A_DEVID) || (a == A_INT_SOURCE) || (a >= A_DATAX0 && a <= A_DATAZ1) || (a == 6'h39);
  endfunction

  function automatic logic is_sample(input logic [5:0] a);
    return (a >= A_DATAX0) && (a <= A_DATAZ1);
  endfunction

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sclk_sync <= '1;
      csn_sync  <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b1;
      csn_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], iSCLK};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], iCSN};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], iSDI};
      sclk_q    <= sclk_s;
      csn_q     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q & ~csn_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~csn_s;
  assign csn_rise  = csn_s & ~csn_q;
  assign csn_fall  = ~csn_s & csn_q;

  assign rx_next   = {rx[6:0], sdi_s};
  assign addr_next = mb ? addr + 6'd1 : addr;
  assign cap_vld   = iSAMPLE_VALID & regs[A_POWER_CTL][3];

  // Samples never land mid-transfer so a burst of DATAX0..DATAZ1 stays coherent.
  always_comb begin
    load_vld = 1'b0;
    load_x   = pend_x;
    load_y   = pend_y;
    load_z   = pend_z;
    if (csn_s) begin
      if (cap_vld) begin
        load_vld = 1'b1;
        load_x   = iX_DATA;
        load_y   = iY_DATA;
        load_z   = iZ_DATA;
      end else if (pend) begin
        load_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      pend   <= 1'b0;
      pend_x <= '0;
      pend_y <= '0;
      pend_z <= '0;
    end else if (cap_vld && !csn_s) begin
      pend   <= 1'b1;
      pend_x <= iX_DATA;
      pend_y <= iY_DATA;
      pend_z <= iZ_DATA;
    end else if (load_vld) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      rw       <= 1'b0;
      mb       <= 1'b0;
      addr     <= '0;
      oSDO     <= 1'b1;
      oSDO_OE  <= 1'b0;
      oWR_STB  <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[A_DEVID]   <= DEVID_VAL;
      regs[A_BW_RATE] <= 8'h0A;
    end else begin
      oWR_STB <= 1'b0;
      if (csn_fall) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        oSDO    <= 1'b1;
        oSDO_OE <= 1'b0;
      end else if (csn_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        oSDO    <= 1'b1;
        oSDO_OE <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (sclk_rise) begin
              rx <= rx_next;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                rw      <= rx_next[7];
                mb      <= rx_next[6];
                addr    <= rx_next[5:0];
                state   <= ST_DATA;
                if (rx_next[7]) begin
                  tx      <= regs[rx_next[5:0]];
                  oSDO_OE <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall && rw) begin
              oSDO <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx <= rx_next;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (!rw && !is_ro(addr)) begin
                  regs[addr] <= rx_next;
                  oWR_STB    <= 1'b1;
                  oWR_ADDR   <= addr;
                  oWR_DATA   <= rx_next;
                end
                if (rw && is_sample(addr)) regs[A_INT_SOURCE][7] <= 1'b0;
                addr <= addr_next;
                if (rw) tx <= regs[addr_next];
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
      // Placed last so a capture wins over a same-cycle DATA_READY clear.
      if (load_vld) begin
        regs[A_DATAX0]           <= load_x[7:0];
        regs[A_DATAX1]           <= load_x[15:8];
        regs[A_DATAY0]           <= load_y[7:0];
        regs[A_DATAY1]           <= load_y[15:8];
        regs[A_DATAZ0]           <= load_z[7:0];
        regs[A_DATAZ1]           <= load_z[15:8];
        regs[A_INT_SOURCE][7]    <= 1'b1;
      end
    end
  end

  assign act = regs[A_INT_SOURCE] & regs[A_INT_ENABLE];

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      oINT1 <= 1'b0;
      oINT2 <= 1'b0;
    end else begin
      oINT1 <= (|(act & ~regs[A_INT_MAP])) ^ regs[A_DATA_FORMAT][5];
      oINT2 <= (|(act & regs[A_INT_MAP])) ^ regs[A_DATA_FORMAT][5];
    end
  end

  assign oMEASURE = regs[A_POWER_CTL][3];

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: table of single-byte register transfers plus burst/corner sequences.
module tb_adxl_spi_responder;
  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        csn = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        sdo_oe;
  logic [15:0] x_data = '0;
  logic [15:0] y_data = '0;
  logic [15:0] z_data = '0;
  logic        sample_vld = 1'b0;
  logic        int1;
  logic        int2;
  logic        measure;
  logic        wr_stb;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  typedef struct {
    bit         rd;
    logic [5:0] addr;
    logic [7:0] wdat;
    logic [7:0] exp;
    int         stb;
  } vec_t;

  vec_t vecs[14];

  adxl_spi_responder #(.DEVID_VAL(8'hE5), .SYNC_STAGES(2)) dut (
    .iSPI_CLK(clk), .iRSTN(rst_n), .iSCLK(sclk), .iCSN(csn), .iSDI(sdi),
    .oSDO(sdo), .oSDO_OE(sdo_oe),
    .iX_DATA(x_data), .iY_DATA(y_data), .iZ_DATA(z_data), .iSAMPLE_VALID(sample_vld),
    .oINT1(int1), .oINT2(int2), .oMEASURE(measure),
    .oWR_STB(wr_stb), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb) stb_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] out, input int n, output logic [7:0] din, output logic [7:0] oe);
    din = '0;
    oe  = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdi  = out[7-i];
      #HALF;
      din[7-i] = sdo;
      oe[7-i]  = sdo_oe;
      sclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic csn_low();
    csn = 1'b0;
    #100;
  endtask

  task automatic csn_high();
    #HALF;
    csn = 1'b1;
    #100;
  endtask

  task automatic xfer(input bit rd, input bit mb, input logic [5:0] a, input logic [7:0] wd, output logic [7:0] rdat);
    logic [7:0] d, oe;
    csn_low();
    spi_bits({rd, mb, a}, 8, d, oe);
    spi_bits(wd, 8, rdat, oe);
    csn_high();
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x;
    y_data = y;
    z_data = z;
    sample_vld = 1'b1;
    #10;
    sample_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sdo"}, sdo, 1'b1);
    check({tag, " sdo_oe"}, sdo_oe, 1'b0);
    check({tag, " int1"}, int1, 1'b0);
    check({tag, " int2"}, int2, 1'b0);
    check({tag, " wr_stb"}, wr_stb, 1'b0);
    check({tag, " wr_addr"}, wr_addr, 6'h00);
    check({tag, " wr_data"}, wr_data, 8'h00);
    check({tag, " measure"}, measure, 1'b0);
  endtask

  initial begin
    logic [7:0] d, d2, oe, oe2;
    logic [7:0] burst_exp[6];
    int stb0;

    vecs[0]  = '{1'b0, 6'h2F, 8'h10, 8'h00, 1};
    vecs[1]  = '{1'b1, 6'h2F, 8'h00, 8'h10, 0};
    vecs[2]  = '{1'b0, 6'h32, 8'h55, 8'h00, 0};
    vecs[3]  = '{1'b1, 6'h32, 8'h00, 8'h00, 0};
    vecs[4]  = '{1'b1, 6'h2C, 8'h00, 8'h0A, 0};
    vecs[5]  = '{1'b0, 6'h00, 8'h12, 8'h00, 0};
    vecs[6]  = '{1'b1, 6'h00, 8'h00, 8'hE5, 0};
    vecs[7]  = '{1'b0, 6'h1D, 8'hA5, 8'h00, 1};
    vecs[8]  = '{1'b1, 6'h1D, 8'h00, 8'hA5, 0};
    vecs[9]  = '{1'b0, 6'h30, 8'hFF, 8'h00, 0};
    vecs[10] = '{1'b1, 6'h30, 8'h00, 8'h00, 0};
    vecs[11] = '{1'b0, 6'h2D, 8'h08, 8'h00, 1};
    vecs[12] = '{1'b0, 6'h2E, 8'h80, 8'h00, 1};
    vecs[13] = '{1'b0, 6'h2F, 8'h80, 8'h00, 1};

    #20;
    check_reset_outputs("reset");
    #30;
    rst_n = 1'b1;
    #50;

    // Plain read of DEVID, with output-enable only during the data byte.
    csn_low();
    spi_bits(8'h80, 8, d, oe);
    spi_bits(8'h00, 8, d2, oe2);
    check("devid oe byte1", oe, 8'h00);
    check("devid data", d2, 8'hE5);
    check("devid oe byte2", oe2, 8'hFF);
    csn_high();
    check("oe after csn", sdo_oe, 1'b0);

    for (int i = 0; i < 14; i++) begin
      stb0 = stb_cnt;
      xfer(vecs[i].rd, 1'b0, vecs[i].addr, vecs[i].wdat, d);
      check($sformatf("vec%0d stb count", i), stb_cnt - stb0, vecs[i].stb);
      if (vecs[i].rd) check($sformatf("vec%0d rdata", i), d, vecs[i].exp);
      if (vecs[i].stb == 1) begin
        check($sformatf("vec%0d wr_addr", i), wr_addr, vecs[i].addr);
        check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].wdat);
      end
    end
    check("measure on", measure, 1'b1);
    check("int2 idle", int2, 1'b0);

    strobe(16'h0123, 16'hFF80, 16'h0001);
    #50;
    check("int2 after sample", int2, 1'b1);
    check("int1 after sample", int1, 1'b0);
    xfer(1'b1, 1'b0, 6'h30, 8'h00, d);
    check("int_source ready", d, 8'h80);

    // Burst of the sample registers; a fresh sample mid-burst must stay pending.
    burst_exp[0] = 8'h23; burst_exp[1] = 8'h01; burst_exp[2] = 8'h80;
    burst_exp[3] = 8'hFF; burst_exp[4] = 8'h01; burst_exp[5] = 8'h00;
    csn_low();
    spi_bits(8'hF2, 8, d, oe);
    for (int b = 0; b < 6; b++) begin
      spi_bits(8'h00, 8, d, oe);
      check($sformatf("burst byte%0d", b), d, burst_exp[b]);
      if (b == 0) begin
        #50;
        check("int2 cleared by read", int2, 1'b0);
      end
      if (b == 1) strobe(16'h7FFF, 16'hFF80, 16'h0001);
    end
    #50;
    check("int2 low while pending", int2, 1'b0);
    csn_high();
    check("int2 after pending apply", int2, 1'b1);
    csn_low();
    spi_bits(8'hF2, 8, d, oe);
    spi_bits(8'h00, 8, d, oe);
    check("new x0", d, 8'hFF);
    spi_bits(8'h00, 8, d, oe);
    check("new x1", d, 8'h7F);
    csn_high();
    check("int2 cleared again", int2, 1'b0);

    xfer(1'b0, 1'b0, 6'h2D, 8'h00, d);
    check("measure off", measure, 1'b0);
    strobe(16'h1111, 16'h2222, 16'h3333);
    #50;
    xfer(1'b1, 1'b0, 6'h32, 8'h00, d);
    check("strobe ignored", d, 8'hFF);

    xfer(1'b0, 1'b0, 6'h31, 8'h20, d);
    #50;
    check("int1 inverted", int1, 1'b1);
    check("int2 inverted", int2, 1'b1);
    xfer(1'b0, 1'b0, 6'h31, 8'h00, d);

    // Partial data byte is dropped on CSN rise.
    stb0 = stb_cnt;
    csn_low();
    spi_bits(8'h31, 8, d, oe);
    spi_bits(8'hFF, 5, d, oe);
    csn_high();
    check("partial no stb", stb_cnt - stb0, 0);
    xfer(1'b1, 1'b0, 6'h31, 8'h00, d);
    check("partial no write", d, 8'h00);
    xfer(1'b1, 1'b0, 6'h00, 8'h00, d);
    check("devid after partial", d, 8'hE5);

    csn_low();
    spi_bits(8'hFF, 8, d, oe);
    spi_bits(8'h00, 8, d, oe);
    check("wrap byte 0x3F", d, 8'h00);
    spi_bits(8'h00, 8, d, oe);
    check("wrap byte 0x00", d, 8'hE5);
    csn_high();

    csn_low();
    spi_bits(8'h80, 8, d, oe);
    spi_bits(8'h00, 8, d, oe);
    spi_bits(8'h00, 8, d2, oe);
    check("no-mb repeat", {d, d2}, 16'hE5E5);
    csn_high();

    csn_low();
    spi_bits(8'h80, 8, d, oe);
    spi_bits(8'h00, 4, d, oe);
    check("oe before reset", sdo_oe, 1'b1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid reset");
    #8;
    sclk = 1'b1;
    csn = 1'b1;
    #50;
    rst_n = 1'b1;
    #50;
    xfer(1'b1, 1'b0, 6'h2F, 8'h00, d);
    check("int_map after reset", d, 8'h00);
    xfer(1'b1, 1'b0, 6'h2C, 8'h00, d);
    check("bw_rate after reset", d, 8'h0A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
